// File: rtl/mux_pipe_pkg.sv
// Shared definitions for the registered N-input operand selector:
// occupancy state encoding, level width and the select clamp rule.
package mux_pipe_pkg;

  localparam int LEVEL_W = 2;

  // Encoding doubles as the occupancy count driven on Level.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Out-of-range codes map to the last input so legacy decode encodings keep their meaning.
  function automatic int sel_clamp(input int op, input int num_in);
    return (op < num_in) ? op : num_in - 1;
  endfunction

endpackage

// File: rtl/mux_nin_comb.sv
// Purely combinational N-input selector over a flattened input bus,
// clamping out-of-range select codes to the last input.
module mux_nin_comb
  import mux_pipe_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 3,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        dout
);

  always_comb begin
    int idx;
    idx  = sel_clamp(int'(sel), NUM_IN);
    dout = din[(NUM_IN-1)*WIDTH +: WIDTH];
    for (int k = 0; k < NUM_IN; k++) begin
      if (idx == k) dout = din[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/mux_nin_pipe.sv
// Registered operand selector with valid/ready handshake and a two-entry
// skid buffer (main drives Output, skid absorbs one beat of backpressure).
module mux_nin_pipe
  import mux_pipe_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 3,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                    CLK,
  input  logic                    Reset_n,
  input  logic [NUM_IN*WIDTH-1:0] In,
  input  logic [SEL_W-1:0]        Op,
  input  logic                    InValid,
  output logic                    InReady,
  output logic [WIDTH-1:0]        Output,
  output logic                    OutValid,
  input  logic                    OutReady,
  output logic [LEVEL_W-1:0]      Level
);

  state_t           state;
  state_t           stateNext;
  logic [WIDTH-1:0] selData;
  logic [WIDTH-1:0] mainData;
  logic [WIDTH-1:0] skidData;
  logic             accept;
  logic             pop;
  logic             loadMainSel;
  logic             loadMainSkid;
  logic             loadSkid;

  mux_nin_comb #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_sel (
    .din  (In),
    .sel  (Op),
    .dout (selData)
  );

  assign accept = InValid && InReady;
  assign pop    = OutValid && OutReady;

  always_comb begin
    stateNext    = state;
    loadMainSel  = 1'b0;
    loadMainSkid = 1'b0;
    loadSkid     = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          stateNext   = ONE;
          loadMainSel = 1'b1;
        end
      end
      ONE: begin
        if (accept && pop) begin
          loadMainSel = 1'b1;
        end else if (accept) begin
          stateNext = FULL;
          loadSkid  = 1'b1;
        end else if (pop) begin
          stateNext = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          stateNext    = ONE;
          loadMainSkid = 1'b1;
        end
      end
      default: stateNext = EMPTY;
    endcase
  end

  // InReady is registered from the next state so it never depends on OutReady combinationally.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= EMPTY;
      InReady <= 1'b0;
    end else begin
      state   <= stateNext;
      InReady <= (stateNext != FULL);
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      mainData <= '0;
      skidData <= '0;
    end else begin
      if (loadMainSel)       mainData <= selData;
      else if (loadMainSkid) mainData <= skidData;
      if (loadSkid)          skidData <= selData;
    end
  end

  assign Output   = mainData;
  assign OutValid = (state != EMPTY);
  assign Level    = state;

endmodule

// File: tb/tb_mux_nin_pipe.sv
// Directed and stall-randomised checks of mux_nin_pipe (WIDTH=16, NUM_IN=3)
// against hand-computed values and a FIFO reference queue.
module tb_mux_nin_pipe;

  localparam logic [15:0] IN0 = 16'h0541;
  localparam logic [15:0] IN1 = 16'h2732;
  localparam logic [15:0] IN2 = 16'h0159;

  logic        CLK;
  logic        Reset_n;
  logic [47:0] In;
  logic [1:0]  Op;
  logic        InValid;
  logic        InReady;
  logic [15:0] Output;
  logic        OutValid;
  logic        OutReady;
  logic [1:0]  Level;

  int checks   = 0;
  int failures = 0;

  logic [15:0] expQ[$];

  mux_nin_pipe #(
    .WIDTH  (16),
    .NUM_IN (3)
  ) dut (
    .CLK      (CLK),
    .Reset_n  (Reset_n),
    .In       (In),
    .Op       (Op),
    .InValid  (InValid),
    .InReady  (InReady),
    .Output   (Output),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Level    (Level)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [1:0] op, input logic ordy);
    InValid  = iv;
    Op       = op;
    OutReady = ordy;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [15:0] modelSel(input logic [47:0] v, input logic [1:0] op);
    case (op)
      2'd0:    return v[15:0];
      2'd1:    return v[31:16];
      default: return v[47:32];
    endcase
  endfunction

  initial begin
    logic [63:0] r;
    logic        willAccept;
    logic        willPop;
    int          accepted;
    int          cycles;

    In = {IN2, IN1, IN0};
    Reset_n = 1'b0;
    applyStimulus(1'b0, 2'd0, 1'b0);

    // Reset state
    #1;
    checkOutput("rst_level", 32'(Level), 32'd0);
    checkOutput("rst_outvalid", 32'(OutValid), 32'd0);
    checkOutput("rst_output", 32'(Output), 32'h0);
    checkOutput("rst_inready", 32'(InReady), 32'd0);
    repeat (2) @(negedge CLK);
    Reset_n = 1'b1;
    #1;
    checkOutput("rel_inready_before_edge", 32'(InReady), 32'd0);
    tick();
    checkOutput("rel_inready_after_edge", 32'(InReady), 32'd1);

    // Test 1: single accept then pop
    $display("[TB] single transfer");
    applyStimulus(1'b1, 2'd0, 1'b1);
    tick();
    checkOutput("t1_output", 32'(Output), 32'(IN0));
    checkOutput("t1_outvalid", 32'(OutValid), 32'd1);
    checkOutput("t1_level", 32'(Level), 32'd1);
    applyStimulus(1'b0, 2'd0, 1'b1);
    tick();
    checkOutput("t1_level_after_pop", 32'(Level), 32'd0);
    checkOutput("t1_outvalid_after_pop", 32'(OutValid), 32'd0);
    checkOutput("t1_output_held", 32'(Output), 32'(IN0));

    // Test 2: back-to-back with every select code, including out-of-range 3
    $display("[TB] back-to-back selects");
    applyStimulus(1'b1, 2'd0, 1'b1);
    tick();
    checkOutput("t2_op0", 32'(Output), 32'(IN0));
    checkOutput("t2_op0_level", 32'(Level), 32'd1);
    applyStimulus(1'b1, 2'd1, 1'b1);
    tick();
    checkOutput("t2_op1", 32'(Output), 32'(IN1));
    checkOutput("t2_op1_level", 32'(Level), 32'd1);
    applyStimulus(1'b1, 2'd2, 1'b1);
    tick();
    checkOutput("t2_op2", 32'(Output), 32'(IN2));
    checkOutput("t2_op2_valid", 32'(OutValid), 32'd1);
    applyStimulus(1'b1, 2'd3, 1'b1);
    tick();
    checkOutput("t2_op3_clamp", 32'(Output), 32'(IN2));
    checkOutput("t2_op3_level", 32'(Level), 32'd1);
    applyStimulus(1'b0, 2'd0, 1'b1);
    tick();
    checkOutput("t2_drained", 32'(Level), 32'd0);

    // Test 3: backpressure fills both entries and drops InReady
    $display("[TB] backpressure");
    applyStimulus(1'b1, 2'd1, 1'b0);
    tick();
    checkOutput("t3_level1", 32'(Level), 32'd1);
    checkOutput("t3_inready1", 32'(InReady), 32'd1);
    checkOutput("t3_out1", 32'(Output), 32'(IN1));
    applyStimulus(1'b1, 2'd2, 1'b0);
    tick();
    checkOutput("t3_level2", 32'(Level), 32'd2);
    checkOutput("t3_inready0", 32'(InReady), 32'd0);
    checkOutput("t3_out_stable", 32'(Output), 32'(IN1));
    applyStimulus(1'b1, 2'd0, 1'b0);
    tick();
    checkOutput("t3_third_refused", 32'(Level), 32'd2);
    checkOutput("t3_out_still_stable", 32'(Output), 32'(IN1));
    applyStimulus(1'b0, 2'd0, 1'b1);
    tick();
    checkOutput("t3_pop_skid", 32'(Output), 32'(IN2));
    checkOutput("t3_level_after_pop", 32'(Level), 32'd1);
    checkOutput("t3_inready_back", 32'(InReady), 32'd1);
    tick();
    checkOutput("t3_empty", 32'(Level), 32'd0);

    // Test 4: simultaneous accept and pop in ONE
    $display("[TB] accept with pop");
    applyStimulus(1'b1, 2'd0, 1'b0);
    tick();
    checkOutput("t4_load", 32'(Output), 32'(IN0));
    applyStimulus(1'b1, 2'd2, 1'b1);
    tick();
    checkOutput("t4_level_stays", 32'(Level), 32'd1);
    checkOutput("t4_output_swap", 32'(Output), 32'(IN2));
    applyStimulus(1'b0, 2'd0, 1'b1);
    tick();
    checkOutput("t4_empty", 32'(Level), 32'd0);

    // Test 5: asynchronous reset while FULL
    $display("[TB] async reset while full");
    applyStimulus(1'b1, 2'd1, 1'b0);
    tick();
    applyStimulus(1'b1, 2'd0, 1'b0);
    tick();
    checkOutput("t5_full", 32'(Level), 32'd2);
    applyStimulus(1'b0, 2'd0, 1'b0);
    #2;
    Reset_n = 1'b0;
    #1;
    checkOutput("t5_rst_outvalid", 32'(OutValid), 32'd0);
    checkOutput("t5_rst_level", 32'(Level), 32'd0);
    checkOutput("t5_rst_output", 32'(Output), 32'h0);
    checkOutput("t5_rst_inready", 32'(InReady), 32'd0);
    @(negedge CLK);
    Reset_n = 1'b1;
    tick();
    checkOutput("t5_rel_inready", 32'(InReady), 32'd1);
    checkOutput("t5_rel_level", 32'(Level), 32'd0);
    applyStimulus(1'b1, 2'd2, 1'b1);
    tick();
    checkOutput("t5_post_output", 32'(Output), 32'(IN2));
    checkOutput("t5_post_level", 32'(Level), 32'd1);
    applyStimulus(1'b0, 2'd0, 1'b1);
    tick();
    checkOutput("t5_post_empty", 32'(Level), 32'd0);

    // Test 6: random stalls against a reference queue
    $display("[TB] random stalls");
    accepted = 0;
    cycles   = 0;
    while (accepted < 1000 && cycles < 20000) begin
      r  = {$urandom(), $urandom()};
      In = r[47:0];
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      willAccept = InValid && InReady;
      willPop    = OutValid && OutReady;
      if (willPop) begin
        if (expQ.size() == 0) begin
          checkOutput("rnd_unexpected_pop", 32'(OutValid), 32'd0);
        end else begin
          checkOutput("rnd_data", 32'(Output), 32'(expQ.pop_front()));
        end
      end
      if (willAccept) begin
        expQ.push_back(modelSel(In, Op));
        accepted++;
      end
      tick();
      cycles++;
      checkOutput("rnd_level", 32'(Level), 32'(expQ.size()));
    end
    checkOutput("rnd_budget", 32'(accepted), 32'd1000);

    applyStimulus(1'b0, 2'd0, 1'b1);
    cycles = 0;
    while (expQ.size() != 0 && cycles < 10) begin
      if (OutValid) checkOutput("drain_data", 32'(Output), 32'(expQ.pop_front()));
      else          checkOutput("drain_valid", 32'(OutValid), 32'd1);
      tick();
      cycles++;
    end
    checkOutput("drain_queue_empty", 32'(expQ.size()), 32'd0);
    checkOutput("drain_level", 32'(Level), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_nin_pipe.md
# mux_nin_pipe

Parametrised, registered N-input operand selector with a valid/ready handshake and a two-entry skid buffer. It replaces the fixed 3-bit/3-input combinational operand mux on the accumulator datapath, where the selected operand must be registered between the decode and ALU stages without stalling throughput. Out-of-range select codes resolve to the last input, so that existing decode encodings keep their meaning.

## Interface
- `WIDTH`, 16: data width of each input and of the output.
- `NUM_IN`, 3: number of inputs, minimum 2.
- `SEL_W`, `$clog2(NUM_IN)`: width of `Op`. This value is derived and must not be overridden.
- `CLK` input 1: the single clock. All state is rising-edge triggered.
- `Reset_n` input 1: asynchronous, active-low reset.
- `In` input `NUM_IN*WIDTH`: flattened inputs. Input k occupies `In[k*WIDTH +: WIDTH]`.
- `Op` input `SEL_W`: select code, sampled together with `In` on accept.
- `InValid` input 1: upstream offers `In`/`Op`.
- `InReady` output 1: the block can accept. This output is registered.
- `Output` output `WIDTH`: selected data.
- `OutValid` output 1: `Output` holds valid data.
- `OutReady` input 1: downstream consumes.
- `Level` output 2: occupancy, range 0..2.

## Operation
- Accept occurs when `InValid && InReady` at a rising edge. Selection rule:
  - If `Op < NUM_IN`, the captured value is input `Op`.
  - Otherwise, the captured value is input `NUM_IN-1`.
  - `In` and `Op` are don't-care when no accept occurs.
- Pop occurs when `OutValid && OutReady` at a rising edge.
- Storage is two registers: main (drives `Output`) and skid.
  - States: EMPTY (Level=0), ONE (Level=1, main valid), FULL (Level=2, main and skid valid).
  - EMPTY, on accept: go to ONE, with main = selected value.
  - ONE, accept without pop: go to FULL, with skid = selected value.
  - ONE, pop without accept: go to EMPTY.
  - ONE, accept and pop together: stay in ONE, with main = selected value.
  - FULL, pop: go to ONE, with main = skid. Accept is impossible in FULL because `InReady` is 0.
  - No other transitions exist.
- Order is strictly FIFO. Data is never dropped or duplicated.
- `InReady` = (next state != FULL), registered. It falls the cycle after FULL is entered and rises the cycle after a pop out of FULL.
- `OutValid` = (state != EMPTY).
- `Output` holds its last value while in EMPTY. Downstream must ignore it.
- `Output` is stable while `OutValid && !OutReady`.

## Timing
- Reset values (asynchronous, effective immediately on `Reset_n` low):
  - State = EMPTY, `Level` = 0, `OutValid` = 0, `Output` = 0.
  - Skid register = 0.
  - `InReady` = 0 while `Reset_n` is low, and 1 from the first rising edge after release.
- Latency: data accepted at edge N is on `Output` with `OutValid` = 1 after edge N.
- Throughput: one transfer per cycle in steady state while `OutReady` = 1.
- Backpressure: with `OutReady` held low, a source that asserts `InValid` continuously gets 2 accepts, and then `InReady` = 0.
- Reset asserted mid-operation: all contents are discarded. No transfer completes on the edge coincident with reset.
- All outputs are glitch-free registers, except `OutValid`, which is decoded from state registers only.

## Structure
- Package `mux_pipe_pkg` holds:
  - the state encoding typedef (EMPTY/ONE/FULL, 2 bits);
  - constant `LEVEL_W` = 2;
  - function `sel_clamp(op, num_in)`, which returns the effective index.
- Sub-module `mux_nin_comb` (parameters `WIDTH`, `NUM_IN`): purely combinational, flattened input with clamp-to-last select. It is reusable by ALU source selection.
- The top level contains the state machine, the main and skid registers, and the `InReady` register.

## Test plan
All scenarios use `WIDTH`=16 and `NUM_IN`=3, with In0=0x0541, In1=0x2732, In2=0x0159.
1. Reset, then `Op`=0 with `InValid` for 1 cycle and `OutReady`=1 → `Output`=0x0541 and `OutValid`=1 exactly one cycle after the accept. `Level` returns to 0 after the pop.
2. `Op` = 0, 1, 2, 3 on back-to-back accepts with `OutReady`=1 → `Output` sequence 0x0541, 0x2732, 0x0159, 0x0159. One result per cycle, no bubbles.
3. `OutReady`=0 while presenting `Op`=1 then `Op`=2, with `InValid` held → `Level`=2 and `InReady`=0 on the next cycle. The third offer is not accepted. Raising `OutReady` then yields 0x2732 followed by 0x0159.
4. In ONE state, accept and pop in the same cycle with `Op`=2 → `Level` stays 1 and `Output` changes to 0x0159.
5. In FULL state, drop `Reset_n` between clock edges → `OutValid`, `Level` and `Output` go to 0 without waiting for an edge. After release, the next accept is delivered normally.
6. A random-stall bench (`InValid` and `OutReady` at 50%, 1000 transfers) is checked against a scoreboard model → zero mismatches and no loss or duplication.
